// File: rtl/lock_responder_pkg.sv
// Shared types for the lock responder.
// Optional stats widths are used when LOCK_RESPONDER_STATS_EN is set.
package lock_responder_pkg;

  typedef enum logic {
    LockAcquire = 1'b0,
    LockRelease = 1'b1
  } lock_op_e;

  typedef enum logic {
    StFree = 1'b0,
    StHeld = 1'b1
  } lock_state_e;

  localparam int LeaseW     = 16;
  localparam int GrantCntW  = 32;
  localparam int FailCntW   = 32;
  localparam int ExpireCntW = 16;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/lock_responder_if.sv
// Trial/verdict bundle between initiators and the lock responder.
// Stats outputs exist only with LOCK_RESPONDER_STATS_EN.
interface lock_responder_if #(
  parameter int NumReq = 4
);
  localparam int IdxW = $clog2(NumReq);

  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_op_i;
  logic [NumReq-1:0] rsp_valid_o;
  logic [NumReq-1:0] rsp_ok_o;
  logic              locked_o;
  logic [IdxW-1:0]   owner_o;
  logic              expired_o;
`ifdef LOCK_RESPONDER_STATS_EN
  logic [31:0]       grant_cnt_o;
  logic [31:0]       fail_cnt_o;
  logic [15:0]       expire_cnt_o;

  modport master (
    output req_valid_i, req_op_i,
    input  rsp_valid_o, rsp_ok_o,
    input  locked_o, owner_o, expired_o,
    input  grant_cnt_o, fail_cnt_o,
    input  expire_cnt_o
  );

  modport slave (
    input  req_valid_i, req_op_i,
    output rsp_valid_o, rsp_ok_o,
    output locked_o, owner_o, expired_o,
    output grant_cnt_o, fail_cnt_o,
    output expire_cnt_o
  );
`else
  modport master (
    output req_valid_i, req_op_i,
    input  rsp_valid_o, rsp_ok_o,
    input  locked_o, owner_o, expired_o
  );

  modport slave (
    input  req_valid_i, req_op_i,
    output rsp_valid_o, rsp_ok_o,
    output locked_o, owner_o, expired_o
  );
`endif

endinterface

// File: rtl/lock_rr_pick.sv
// Rotate-priority find-first-one from a start index.
// Purely combinational; used for round-robin lock arbitration.
module lock_rr_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_start,
  output logic              o_valid,
  output logic [IdxW-1:0]   o_idx
);

  logic [IdxW-1:0] w_sel;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sel   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      w_sel = IdxW'((int'(i_start) + k) % NumReq);
      if (i_req[w_sel]) begin
        o_valid = 1'b1;
        o_idx   = w_sel;
      end
    end
  end

endmodule

// File: rtl/lock_responder.sv
// Shared-lock responder with round-robin grant and lease expiry.
// LOCK_RESPONDER_STATS_EN adds saturating grant/fail/expire counters.
module lock_responder
  import lock_responder_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int LeaseCycles = 1024
) (
  input logic       clk_i,
  input logic       rst_i,
  lock_responder_if.slave bus
);

  localparam int IdxW = $clog2(NumReq);
  localparam logic [LeaseW-1:0] LeaseInit =
    LeaseW'(LeaseCycles);
  localparam bit LeaseEn = (LeaseCycles > 0);

  lock_state_e       r_state;
  lock_state_e       w_state_nxt;
  logic [IdxW-1:0]   r_owner;
  logic [IdxW-1:0]   w_owner_nxt;
  logic [LeaseW-1:0] r_lease;
  logic [LeaseW-1:0] w_lease_nxt;
  logic [IdxW-1:0]   r_rr;
  logic [IdxW-1:0]   w_rr_nxt;
  logic [NumReq-1:0] r_rsp_valid;
  logic [NumReq-1:0] r_rsp_ok;
  logic [NumReq-1:0] w_ok;
  logic              r_expired;
  logic              w_expire;

  logic [NumReq-1:0] w_acq;
  logic [NumReq-1:0] w_rel;
  logic              w_held;
  logic              w_own_acq;
  logic              w_own_rel;
  logic              w_pick_valid;
  logic [IdxW-1:0]   w_pick_idx;

  assign w_acq     = bus.req_valid_i & ~bus.req_op_i;
  assign w_rel     = bus.req_valid_i & bus.req_op_i;
  assign w_held    = (r_state == StHeld);
  assign w_own_acq = w_held & w_acq[r_owner];
  assign w_own_rel = w_held & w_rel[r_owner];

  lock_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .i_req   (w_acq),
    .i_start (r_rr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Verdicts and next lock state, all from pre-cycle state.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lease_nxt = r_lease;
    w_rr_nxt    = r_rr;
    w_ok        = '0;
    w_expire    = 1'b0;
    unique case (r_state)
      StFree: begin
        if (w_pick_valid) begin
          w_ok[w_pick_idx] = 1'b1;
          w_state_nxt      = StHeld;
          w_owner_nxt      = w_pick_idx;
          w_lease_nxt      = LeaseInit;
          w_rr_nxt         = IdxW'(wrap_inc(
            int'(w_pick_idx), NumReq));
        end
      end
      StHeld: begin
        w_ok[r_owner] = bus.req_valid_i[r_owner];
        w_expire = LeaseEn
          && (r_lease == LeaseW'(1))
          && !w_own_acq;
        if (w_own_rel || w_expire) begin
          w_state_nxt = StFree;
          w_owner_nxt = '0;
          w_lease_nxt = '0;
        end else if (w_own_acq) begin
          w_lease_nxt = LeaseInit;
        end else if (LeaseEn) begin
          w_lease_nxt = r_lease - LeaseW'(1);
        end
      end
      default: ;
    endcase
  end

  // Lock, lease, round-robin and verdict registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StFree;
      r_owner     <= '0;
      r_lease     <= '0;
      r_rr        <= '0;
      r_rsp_valid <= '0;
      r_rsp_ok    <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_lease     <= w_lease_nxt;
      r_rr        <= w_rr_nxt;
      r_rsp_valid <= bus.req_valid_i;
      r_rsp_ok    <= w_ok;
      r_expired   <= w_expire;
    end
  end

  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_ok_o    = r_rsp_ok;
  assign bus.locked_o    = w_held;
  assign bus.owner_o     = r_owner;
  assign bus.expired_o   = r_expired;

`ifdef LOCK_RESPONDER_STATS_EN
  logic [GrantCntW-1:0]  r_grant_cnt;
  logic [FailCntW-1:0]   r_fail_cnt;
  logic [ExpireCntW-1:0] r_expire_cnt;
  logic [NumReq-1:0]     w_fail;
  logic                  w_grant;
  logic [FailCntW:0]     w_fail_sum;

  assign w_fail     = bus.req_valid_i & ~w_ok;
  assign w_grant    = |(w_ok & w_acq);
  assign w_fail_sum = {1'b0, r_fail_cnt}
    + (FailCntW + 1)'($countones(w_fail));

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant_cnt  <= '0;
      r_fail_cnt   <= '0;
      r_expire_cnt <= '0;
    end else begin
      if (w_grant && (r_grant_cnt != '1))
        r_grant_cnt <= r_grant_cnt + GrantCntW'(1);
      if (w_fail_sum[FailCntW])
        r_fail_cnt <= '1;
      else
        r_fail_cnt <= w_fail_sum[FailCntW-1:0];
      if (w_expire && (r_expire_cnt != '1))
        r_expire_cnt <= r_expire_cnt + ExpireCntW'(1);
    end
  end

  assign bus.grant_cnt_o  = r_grant_cnt;
  assign bus.fail_cnt_o   = r_fail_cnt;
  assign bus.expire_cnt_o = r_expire_cnt;
`endif

endmodule

// File: tb/tb_lock_responder.sv
// Self-checking bench for lock_responder (NumReq=4, LeaseCycles=8).
// Stats counters are checked when LOCK_RESPONDER_STATS_EN is set.
module tb_lock_responder;

  localparam int N     = 4;
  localparam int LEASE = 8;

  logic clk;
  logic rst;

  lock_responder_if #(.NumReq(N)) bus ();

  lock_responder #(
    .NumReq      (N),
    .LeaseCycles (LEASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: abstract lock state.
  bit       m_held;
  int       m_owner;
  int       m_lease;
  int       m_rr;
  logic [3:0] e_valid;
  logic [3:0] e_ok;
  logic       e_expired;
  longint   m_grants;
  longint   m_fails;
  longint   m_expires;

  function automatic void model_reset();
    m_held = 0; m_owner = 0; m_lease = 0; m_rr = 0;
    e_valid = '0; e_ok = '0; e_expired = 1'b0;
    m_grants = 0; m_fails = 0; m_expires = 0;
  endfunction

  function automatic void model_step(
    input logic [3:0] v,
    input logic [3:0] op
  );
    bit found;
    int win;
    bit own_try;
    bit own_acq;
    bit own_rel;
    found = 0; win = 0;
    e_ok = '0; e_expired = 1'b0; e_valid = v;
    if (!m_held) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && v[j] && !op[j]) begin
          found = 1; win = j;
        end
      end
      if (found) begin
        e_ok[win] = 1'b1;
        m_grants++;
        m_held = 1; m_owner = win;
        m_lease = LEASE;
        m_rr = (win + 1) % N;
      end
    end else begin
      own_try = v[m_owner];
      own_acq = own_try && !op[m_owner];
      own_rel = own_try && op[m_owner];
      if (own_try) e_ok[m_owner] = 1'b1;
      if (own_acq) m_grants++;
      if (m_lease == 1 && !own_acq) begin
        e_expired = 1'b1;
        m_expires++;
      end
      if (own_rel || e_expired) begin
        m_held = 0; m_owner = 0; m_lease = 0;
      end else if (own_acq) begin
        m_lease = LEASE;
      end else begin
        m_lease = m_lease - 1;
      end
    end
    for (int i = 0; i < N; i++)
      if (v[i] && !e_ok[i]) m_fails++;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample at next negedge.
  task automatic step(
    input logic [3:0] v,
    input logic [3:0] op
  );
    bus.req_valid_i = v;
    bus.req_op_i    = op;
    model_step(v, op);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(e_valid));
    chk("rsp_ok", 32'(bus.rsp_ok_o & e_valid),
        32'(e_ok));
    chk("locked", 32'(bus.locked_o), 32'(m_held));
    chk("owner", 32'(bus.owner_o), 32'(m_owner));
    chk("expired", 32'(bus.expired_o), 32'(e_expired));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 4'b0);
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] op;
    logic [3:0] ok;
    logic       lk;
    logic [1:0] own;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{4'b1011, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0};
    tbl[2]  = '{4'b1011, 4'b0000, 4'b0010, 1'b1, 2'd1};
    tbl[3]  = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 2'd1};
    tbl[4]  = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd0};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    tbl[7]  = '{4'b0101, 4'b0100, 4'b0100, 1'b0, 2'd0};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0};

    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_ok", 32'(bus.rsp_ok_o), 32'd0);
    chk("rst_locked", 32'(bus.locked_o), 32'd0);
    chk("rst_owner", 32'(bus.owner_o), 32'd0);
    chk("rst_expired", 32'(bus.expired_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table from reset (rr starts at 0).
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].op);
      chk($sformatf("tbl%0d_ok", i),
          32'(bus.rsp_ok_o & tbl[i].v), 32'(tbl[i].ok));
      chk($sformatf("tbl%0d_lk", i),
          32'(bus.locked_o), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d_own", i),
          32'(bus.owner_o), 32'(tbl[i].own));
    end

    // Lease expiry without refresh.
    step(4'b0010, 4'b0000);
    idle(7);
    chk("lease_held7", 32'(bus.locked_o), 32'd1);
    chk("lease_noexp7", 32'(bus.expired_o), 32'd0);
    step(4'b0000, 4'b0000);
    chk("lease_exp", 32'(bus.expired_o), 32'd1);
    chk("lease_free", 32'(bus.locked_o), 32'd0);
    idle(1);
    chk("lease_pulse1", 32'(bus.expired_o), 32'd0);

    // Refresh at cycle 7, then full reloaded lease.
    step(4'b0010, 4'b0000);
    idle(6);
    step(4'b0010, 4'b0000);
    chk("refresh_ok", 32'(bus.rsp_ok_o), 32'b0010);
    chk("refresh_noexp", 32'(bus.expired_o), 32'd0);
    idle(7);
    chk("reload_held", 32'(bus.locked_o), 32'd1);
    step(4'b0001, 4'b0000);
    chk("reload_exp", 32'(bus.expired_o), 32'd1);
    chk("exp_other_fail", 32'(bus.rsp_ok_o), 32'd0);

    // Refresh in the expiry cycle itself.
    step(4'b1000, 4'b0000);
    idle(7);
    step(4'b1000, 4'b0000);
    chk("lastcyc_noexp", 32'(bus.expired_o), 32'd0);
    chk("lastcyc_held", 32'(bus.locked_o), 32'd1);

    // Reset mid-lease with a trial in flight.
    idle(2);
    bus.req_valid_i = 4'b0001;
    bus.req_op_i    = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("amid_locked", 32'(bus.locked_o), 32'd0);
    chk("amid_owner", 32'(bus.owner_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = '0;
    chk("amid_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("amid_expired", 32'(bus.expired_o), 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] v;
      logic [3:0] op;
      v  = 4'($urandom) & 4'($urandom);
      op = 4'($urandom);
      step(v, op);
    end

`ifdef LOCK_RESPONDER_STATS_EN
    chk("grant_cnt", bus.grant_cnt_o, 32'(m_grants));
    chk("fail_cnt", bus.fail_cnt_o, 32'(m_fails));
    chk("expire_cnt", 32'(bus.expire_cnt_o),
        32'(m_expires));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
